// File: rtl/amp_trig_gen.sv
// Multi-channel amplifier trigger generator: a rising edge on trigger_in launches
// one delayed, width-limited pulse per enabled channel, followed by a hold-off.
module amp_trig_gen #(
  parameter int N_CH      = 4,
  parameter int DELAY_W   = 7,
  parameter int WIDTH_W   = 8,
  parameter int HOLDOFF_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    trigger_in,
  input  logic [N_CH-1:0]         trig_out_en,
  input  logic [N_CH*DELAY_W-1:0] trig_out_delay,
  input  logic [N_CH*WIDTH_W-1:0] trig_out_width,
  input  logic [N_CH-1:0]         trig_out_mode,
  input  logic [HOLDOFF_W-1:0]    holdoff,
  output logic [N_CH-1:0]         amp_trig,
  output logic                    busy,
  output logic [15:0]             trig_count,
  output logic [7:0]              missed_count
);

  localparam int CNT_W = DELAY_W + WIDTH_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLDOFF} state_t;

  state_t                 state;
  logic                   trig_d;
  logic                   trig_edge;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [HOLDOFF_W-1:0]   hcnt;
  logic [HOLDOFF_W-1:0]   snap_holdoff;
  logic [N_CH-1:0]        snap_en;
  logic [N_CH-1:0]        snap_mode;
  logic [DELAY_W-1:0]     snap_delay [N_CH];
  logic [WIDTH_W-1:0]     snap_width [N_CH];
  logic [N_CH-1:0]        killed;
  logic [CNT_W-1:0]       win_end [N_CH];
  logic [N_CH-1:0]        snap_eff;
  logic [N_CH-1:0]        run_kill;
  logic [N_CH-1:0]        run_act;
  logic [N_CH-1:0]        ch_done;
  logic [N_CH-1:0]        start_act;
  logic                   any_eff;

  assign trig_edge = trigger_in & ~trig_d;

  // cnt is the index of the current output cycle within the sequence; the
  // registered outputs are computed one index ahead (cnt_nxt).
  always_comb begin
    cnt_nxt   = cnt + CNT_W'(1);
    any_eff   = 1'b0;
    start_act = '0;
    snap_eff  = '0;
    run_kill  = '0;
    run_act   = '0;
    ch_done   = '0;
    for (int i = 0; i < N_CH; i++) begin
      win_end[i]  = CNT_W'(snap_delay[i]) + CNT_W'(snap_width[i]);
      snap_eff[i] = snap_en[i] && (snap_width[i] != '0);
      run_kill[i] = killed[i] | (snap_mode[i] & ~trigger_in);
      run_act[i]  = snap_eff[i] && !run_kill[i] &&
                    (cnt_nxt >= CNT_W'(snap_delay[i])) && (cnt_nxt < win_end[i]);
      ch_done[i]  = !snap_eff[i] || run_kill[i] || (cnt_nxt >= win_end[i]);
      if (trig_out_en[i] && (trig_out_width[i*WIDTH_W +: WIDTH_W] != '0)) begin
        any_eff      = 1'b1;
        start_act[i] = (trig_out_delay[i*DELAY_W +: DELAY_W] == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      trig_d       <= 1'b1;
      cnt          <= '0;
      hcnt         <= '0;
      snap_holdoff <= '0;
      snap_en      <= '0;
      snap_mode    <= '0;
      killed       <= '0;
      amp_trig     <= '0;
      busy         <= 1'b0;
      trig_count   <= '0;
      missed_count <= '0;
      for (int i = 0; i < N_CH; i++) begin
        snap_delay[i] <= '0;
        snap_width[i] <= '0;
      end
    end else begin
      trig_d <= trigger_in;
      if (trig_edge && (state != IDLE) && (missed_count != 8'hFF))
        missed_count <= missed_count + 8'd1;
      case (state)
        IDLE: begin
          if (trig_edge) begin
            snap_en      <= trig_out_en;
            snap_mode    <= trig_out_mode;
            snap_holdoff <= holdoff;
            for (int i = 0; i < N_CH; i++) begin
              snap_delay[i] <= trig_out_delay[i*DELAY_W +: DELAY_W];
              snap_width[i] <= trig_out_width[i*WIDTH_W +: WIDTH_W];
            end
            cnt        <= '0;
            hcnt       <= '0;
            killed     <= '0;
            busy       <= 1'b1;
            trig_count <= trig_count + 16'd1;
            // The edge cycle itself has trigger_in high, so delay-0 channels
            // start immediately regardless of mode.
            if (any_eff) begin
              state    <= RUN;
              amp_trig <= start_act;
            end else begin
              state    <= HOLDOFF;
            end
          end
        end
        RUN: begin
          cnt      <= cnt_nxt;
          killed   <= run_kill;
          amp_trig <= run_act;
          hcnt     <= '0;
          if (&ch_done)
            state <= HOLDOFF;
        end
        HOLDOFF: begin
          if (hcnt >= snap_holdoff) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            hcnt <= hcnt + HOLDOFF_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/amp_trig_gen.md
# amp_trig_gen

Multi-channel amplifier trigger generator, the parametrised successor to the single-channel amplifier trigger. It detects a rising edge on the machine trigger and emits one pulse per enabled channel. Each channel has its own programmable delay, width and pulse mode. A global hold-off and a missed-trigger counter are included. It sits between the trigger input conditioning and the amplifier/kicker drive outputs, in the sample clock domain.

## Interface
- N_CH, 4, number of output channels
- DELAY_W, 7, per-channel delay field width (cycles)
- WIDTH_W, 8, per-channel pulse-width field width (cycles)
- HOLDOFF_W, 10, hold-off field width (cycles)

- clk  in  1  sample clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- trigger_in  in  1  machine trigger, already synchronous to clk
- trig_out_en  in  N_CH  per-channel enable
- trig_out_delay  in  N_CH*DELAY_W  per-channel delay; channel i at [i*DELAY_W +: DELAY_W]
- trig_out_width  in  N_CH*WIDTH_W  per-channel pulse width, packed the same way
- trig_out_mode  in  N_CH  per-channel mode; 0 = fixed width, 1 = gated by trigger_in, capped at width
- holdoff  in  HOLDOFF_W  dead time after a sequence completes
- amp_trig  out  N_CH  trigger outputs, registered
- busy  out  1  sequence in progress or hold-off active
- trig_count  out  16  accepted triggers, wraps
- missed_count  out  8  rising edges ignored while busy, saturating

## Operation
- States: IDLE, RUN, HOLDOFF.
- Edge detect:
  - trig_d is a registered copy of trigger_in.
  - edge = trigger_in & ~trig_d.
  - trig_d resets to 1, so a trigger high at reset release is not an edge.
- IDLE:
  - On edge (cycle k), snapshot en/delay/width/mode for all channels.
  - Clear the timebase counter cnt (DELAY_W+WIDTH_W+1 bits).
  - Increment trig_count and go to RUN.
  - If no channel is effectively enabled (en=1 and width≠0), go straight to HOLDOFF instead. trig_count still increments.
- RUN:
  - cnt increments each cycle.
  - Channel i is active while snapshot en=1 and width≠0 and cnt is in [delay_i, delay_i+width_i−1].
  - Mode 1 additionally requires trigger_in sampled high in the same cycle. Once a mode-1 pulse drops because trigger_in went low, it stays low for the rest of the sequence.
  - Mode 1 with trigger_in low before delay_i expires produces no pulse.
  - The sequence is done when every effectively enabled channel has either completed its window or been terminated.
  - When done, go to HOLDOFF.
- HOLDOFF:
  - Count holdoff cycles, then go to IDLE.
  - holdoff=0 means a single transition cycle.
- Edges seen in RUN or HOLDOFF are ignored and increment missed_count, which saturates at 255.
- Configuration changes after the snapshot have no effect until the next accepted trigger.
- Reset, including mid-sequence:
  - amp_trig=0, busy=0, trig_count=0, missed_count=0, state IDLE, trig_d=1.
  - Takes effect immediately, asynchronously.

## Timing
- Edge sampled at cycle k. Channel i amp_trig is high in cycles k+1+delay_i through k+delay_i+width_i inclusive, i.e. exactly width_i cycles.
- delay=0 gives the minimum latency: output high one cycle after the edge is sampled.
- Mode 1: the output falls on the cycle after trigger_in is sampled low, or at width expiry, whichever comes first.
- busy rises at k+1 and falls in the cycle after the last HOLDOFF count.
- The earliest re-trigger edge is accepted in the first IDLE cycle.
- trig_count updates at k+1.
- missed_count updates one cycle after the ignored edge.
- Maximum sequence length is 2^DELAY_W−1 + 2^WIDTH_W−1 cycles. The cnt width guarantees no wrap.

## Test plan
- Single channel, fixed mode: ch0 en=1, delay=1, width=4, holdoff=0; one edge at k.
  - amp_trig[0] high k+2..k+5.
  - Other channels stay 0.
  - trig_count=1.
- Four channels, fixed mode: delays 0/5/127/3, widths 1/2/255/0.
  - Pulses at k+1 (1 cycle), k+6..k+7, and k+128..k+382.
  - ch3 never pulses.
  - busy falls after ch2 completes.
- Gated mode: ch1 mode=1, delay=2, width=10; trigger_in high for 6 cycles.
  - amp_trig[1] high k+3..k+6 (4 cycles), ending early because trigger_in falls.
  - A repeat with trigger_in held high for 20 cycles gives exactly 10 cycles.
- Hold-off and miss: holdoff=20; second edge inside the hold-off window, third edge after it.
  - Second edge gives no pulse and missed_count=1.
  - Third edge is accepted and trig_count=2.
  - 300 ignored edges leave missed_count saturated at 255.
- Reset mid-pulse: assert rst_n low during a ch2 pulse.
  - amp_trig and busy go 0 without waiting for a clock.
  - Counters read 0.
  - trigger_in held high across reset release produces no pulse.
- Snapshot: change delay and en during RUN.
  - The current sequence uses the old values.
  - The next trigger uses the new values.
